branch_resolve_unit: RTL and testbench

Consumes operand-compare flags (equal, signed less-than, unsigned less-than) from the execute-stage comparators, evaluates the branch/jump condition, and computes the actual target. It checks the result against the fetch-stage prediction. On a mismatch it issues a held redirect to fetch, then squashes a fixed number of wrong-path slots. It also emits the predictor-update strobe and saturating branch/mispredict counters.

---
 rtl/branch_pkg.sv | 24 ++
 rtl/branch_cond.sv | 31 +++
 rtl/branch_resolve_unit.sv | 139 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution slice.
package branch_pkg;

  localparam int BR_XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {S_RUN, S_REDIRECT, S_SQUASH} state_t;

  // Registered resolution result; sized by BR_XLEN, so the top's XLEN must match.
  typedef struct packed {
    logic               taken;
    logic               mispredict;
    logic               illegal;
    logic [BR_XLEN-1:0] target;
    logic [BR_XLEN-1:0] link;
  } resolve_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from comparator flags; jumps are always taken.
module branch_cond import branch_pkg::*; (
  input  logic [2:0] funct3,
  input  logic       eq,
  input  logic       lts,
  input  logic       ltu,
  input  logic       is_jal,
  input  logic       is_jalr,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (is_jal || is_jalr) begin
      taken = 1'b1;
    end else begin
      case (funct3)
        F3_BEQ:  taken = eq;
        F3_BNE:  taken = !eq;
        F3_BLT:  taken = lts;
        F3_BGE:  taken = !lts;
        F3_BLTU: taken = ltu;
        F3_BGEU: taken = !ltu;
        default: illegal = 1'b1;  // 010/011 resolve as not taken
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps, checks the fetch prediction, redirects fetch and
// squashes a fixed number of wrong-path slots after a mispredict.
module branch_resolve_unit import branch_pkg::*; #(
  parameter int XLEN          = 32,
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [2:0]       funct3_i,
  input  logic             is_jal_i,
  input  logic             is_jalr_i,
  input  logic             eq_i,
  input  logic             lts_i,
  input  logic             ltu_i,
  input  logic             pred_taken_i,
  input  logic [XLEN-1:0]  pred_target_i,
  output logic             resolve_valid_o,
  output logic             taken_o,
  output logic             mispredict_o,
  output logic [XLEN-1:0]  link_o,
  output logic             illegal_o,
  output logic             bht_valid_o,
  output logic             bht_taken_o,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  input  logic             redirect_ready_i,
  output logic             squash_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int SQW = (SQUASH_CYCLES < 1) ? 1 : $clog2(SQUASH_CYCLES + 1);

  state_t           state, state_nxt;
  logic [SQW-1:0]   sq_cnt;
  logic             accept, run_acc, is_cond;
  logic             cond_taken, cond_illegal, mispredict;
  logic [XLEN-1:0]  jalr_sum, target, link;
  resolve_t         res_q;
  logic             resolve_q, bht_v_q, bht_t_q;
  logic [XLEN-1:0]  redir_pc_q;
  logic [CNT_W-1:0] bcnt_q, mcnt_q;

  branch_cond u_cond (
    .funct3  (funct3_i),
    .eq      (eq_i),
    .lts     (lts_i),
    .ltu     (ltu_i),
    .is_jal  (is_jal_i),
    .is_jalr (is_jalr_i),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  assign ready_o  = (state != S_REDIRECT);
  assign accept   = valid_i && ready_o;
  assign run_acc  = accept && (state == S_RUN);
  assign squash_o = accept && (state == S_SQUASH);
  assign is_cond  = !is_jal_i && !is_jalr_i;

  assign jalr_sum   = rs1_i + imm_i;
  assign target     = is_jalr_i ? {jalr_sum[XLEN-1:1], 1'b0} : pc_i + imm_i;
  assign link       = pc_i + XLEN'(4);
  // Predicted target only matters when the op is actually taken.
  assign mispredict = (cond_taken != pred_taken_i) ||
                      (cond_taken && (target != pred_target_i));

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:      if (run_acc && mispredict) state_nxt = S_REDIRECT;
      S_REDIRECT: if (redirect_ready_i)
                    state_nxt = (SQUASH_CYCLES == 0) ? S_RUN : S_SQUASH;
      S_SQUASH:   if (sq_cnt == SQW'(1)) state_nxt = S_RUN;
      default:    state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_RUN;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sq_cnt <= '0;
    end else if (state == S_REDIRECT && redirect_ready_i) begin
      sq_cnt <= SQW'(SQUASH_CYCLES);
    end else if (state == S_SQUASH) begin
      sq_cnt <= sq_cnt - SQW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q      <= '0;
      resolve_q  <= 1'b0;
      bht_v_q    <= 1'b0;
      bht_t_q    <= 1'b0;
      redir_pc_q <= '0;
      bcnt_q     <= '0;
      mcnt_q     <= '0;
    end else begin
      resolve_q <= run_acc;
      bht_v_q   <= run_acc && is_cond;
      bht_t_q   <= run_acc && is_cond && cond_taken;
      if (run_acc) begin
        res_q.taken      <= cond_taken;
        res_q.mispredict <= mispredict;
        res_q.illegal    <= cond_illegal;
        res_q.target     <= target;
        res_q.link       <= link;
        if (bcnt_q != '1) bcnt_q <= bcnt_q + CNT_W'(1);
        if (mispredict && mcnt_q != '1) mcnt_q <= mcnt_q + CNT_W'(1);
        // Held until the handshake since the state blocks further accepts.
        if (mispredict) redir_pc_q <= cond_taken ? target : link;
      end
    end
  end

  assign resolve_valid_o  = resolve_q;
  assign taken_o          = res_q.taken;
  assign mispredict_o     = res_q.mispredict;
  assign illegal_o        = res_q.illegal;
  assign link_o           = res_q.link;
  assign bht_valid_o      = bht_v_q;
  assign bht_taken_o      = bht_t_q;
  assign redirect_valid_o = (state == S_REDIRECT);
  assign redirect_pc_o    = redir_pc_q;
  assign branch_cnt_o     = bcnt_q;
  assign mispred_cnt_o    = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboarded random bench for branch_resolve_unit with a spec-level model.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int SQ   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid_i = 1'b0, ready_o;
  logic [XLEN-1:0] pc_i = '0, imm_i = '0, rs1_i = '0, pred_target_i = '0;
  logic [2:0]      funct3_i = '0;
  logic            is_jal_i = 1'b0, is_jalr_i = 1'b0;
  logic            eq_i = 1'b0, lts_i = 1'b0, ltu_i = 1'b0, pred_taken_i = 1'b0;
  logic            resolve_valid_o, taken_o, mispredict_o, illegal_o;
  logic [XLEN-1:0] link_o, redirect_pc_o;
  logic            bht_valid_o, bht_taken_o, redirect_valid_o;
  logic            redirect_ready_i = 1'b0, squash_o;
  logic [CW-1:0]   branch_cnt_o, mispred_cnt_o;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .SQUASH_CYCLES(SQ), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .imm_i(imm_i), .rs1_i(rs1_i), .funct3_i(funct3_i),
    .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i), .eq_i(eq_i), .lts_i(lts_i),
    .ltu_i(ltu_i), .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .resolve_valid_o(resolve_valid_o), .taken_o(taken_o),
    .mispredict_o(mispredict_o), .link_o(link_o), .illegal_o(illegal_o),
    .bht_valid_o(bht_valid_o), .bht_taken_o(bht_taken_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .redirect_ready_i(redirect_ready_i), .squash_o(squash_o),
    .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  typedef struct {
    bit v; logic [31:0] pc, imm, rs1, ptgt; logic [2:0] f3;
    bit jal, jalr, eq, lts, ltu, pt;
  } op_t;

  typedef struct {
    int due; bit taken, misp, ill, bhtv; logic [31:0] link, rpc; int bc, mc;
  } exp_t;

  exp_t q[$];
  int errs = 0, checks = 0, cyc = 0;
  int mode = 0, sq_left = 0, bcnt = 0, mcnt = 0;  // mode: 0 run, 1 redirect, 2 squash
  logic [31:0] rpc = '0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic bit m_taken(op_t o);
    if (o.jal || o.jalr) return 1'b1;
    case (o.f3)
      3'd0: return o.eq;
      3'd1: return !o.eq;
      3'd4: return o.lts;
      3'd5: return !o.lts;
      3'd6: return o.ltu;
      3'd7: return !o.ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(op_t o);
    if (o.jalr) return (o.rs1 + o.imm) & ~32'd1;
    return o.pc + o.imm;
  endfunction

  function automatic op_t idle();
    op_t o;
    o.v = 0; o.pc = '0; o.imm = '0; o.rs1 = '0; o.ptgt = '0; o.f3 = '0;
    o.jal = 0; o.jalr = 0; o.eq = 0; o.lts = 0; o.ltu = 0; o.pt = 0;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int k;
    k = $urandom_range(0, 9);
    o = idle();
    o.v = ($urandom_range(0, 3) != 0);
    o.pc = $urandom & ~32'd3;
    o.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
    o.rs1 = $urandom;
    o.f3 = 3'($urandom);
    o.jal = (k == 0); o.jalr = (k == 1);
    o.eq = 1'($urandom); o.lts = 1'($urandom); o.ltu = 1'($urandom);
    if ($urandom_range(0, 9) < 7) begin
      o.pt = m_taken(o); o.ptgt = m_target(o);
    end else begin
      o.pt = 1'($urandom);
      o.ptgt = $urandom_range(0, 1) ? m_target(o) + 32'd4 : $urandom;
    end
    return o;
  endfunction

  // One cycle: called at a negedge, returns at the next negedge.
  task automatic step(input op_t o, input bit rdy);
    bit t, m;
    logic [31:0] tg;
    exp_t e;
    int nmode;
    chk("ready_o", ready_o, mode != 1);
    chk("redirect_valid_o", redirect_valid_o, mode == 1);
    if (mode == 1) chk("redirect_pc_o", redirect_pc_o, rpc);
    valid_i = o.v; pc_i = o.pc; imm_i = o.imm; rs1_i = o.rs1; funct3_i = o.f3;
    is_jal_i = o.jal; is_jalr_i = o.jalr; eq_i = o.eq; lts_i = o.lts; ltu_i = o.ltu;
    pred_taken_i = o.pt; pred_target_i = o.ptgt; redirect_ready_i = rdy;
    #1;
    chk("squash_o", squash_o, mode == 2 && o.v);
    nmode = mode;
    if (mode == 0 && o.v) begin
      t = m_taken(o); tg = m_target(o);
      m = (t != o.pt) || (t && tg != o.ptgt);
      if (bcnt < CMAX) bcnt++;
      if (m && mcnt < CMAX) mcnt++;
      e.due = cyc + 1; e.taken = t; e.misp = m;
      e.ill = !o.jal && !o.jalr && (o.f3 == 3'd2 || o.f3 == 3'd3);
      e.bhtv = !o.jal && !o.jalr; e.link = o.pc + 32'd4;
      e.rpc = t ? tg : o.pc + 32'd4; e.bc = bcnt; e.mc = mcnt;
      q.push_back(e);
      if (m) begin nmode = 1; rpc = e.rpc; end
    end else if (mode == 1) begin
      if (rdy) begin nmode = (SQ == 0) ? 0 : 2; sq_left = SQ; end
    end else if (mode == 2) begin
      sq_left--;
      if (sq_left == 0) nmode = 0;
    end
    @(negedge clk);
    mode = nmode;
  endtask

  task automatic reset_mid();
    valid_i = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst redirect_valid_o", redirect_valid_o, 0);
    chk("rst ready_o", ready_o, 1);
    chk("rst branch_cnt_o", branch_cnt_o, 0);
    chk("rst mispred_cnt_o", mispred_cnt_o, 0);
    chk("rst resolve_valid_o", resolve_valid_o, 0);
    chk("rst squash_o", squash_o, 0);
    q.delete(); mode = 0; sq_left = 0; bcnt = 0; mcnt = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every presented resolution against the scoreboard.
  initial forever begin
    bit due_now;
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (rst_n) begin
      due_now = (q.size() > 0) && (q[0].due == cyc);
      chk("resolve_valid_o", resolve_valid_o, due_now);
      if (due_now) begin
        e = q.pop_front();
        if (resolve_valid_o) begin
          chk("taken_o", taken_o, e.taken);
          chk("mispredict_o", mispredict_o, e.misp);
          chk("illegal_o", illegal_o, e.ill);
          chk("link_o", link_o, e.link);
          chk("bht_valid_o", bht_valid_o, e.bhtv);
          chk("bht_taken_o", bht_taken_o, e.bhtv && e.taken);
          chk("branch_cnt_o", branch_cnt_o, 64'(e.bc));
          chk("mispred_cnt_o", mispred_cnt_o, 64'(e.mc));
          chk("redirect_valid_o@resolve", redirect_valid_o, e.misp);
          if (e.misp) chk("redirect_pc_o@resolve", redirect_pc_o, e.rpc);
        end
      end else begin
        chk("bht_valid_o idle", bht_valid_o, 0);
        if (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      end
    end
  end

  initial begin
    op_t o;
    #3;
    chk("init ready_o", ready_o, 1);
    chk("init resolve_valid_o", resolve_valid_o, 0);
    chk("init redirect_valid_o", redirect_valid_o, 0);
    chk("init branch_cnt_o", branch_cnt_o, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // BEQ correct predict
    o = idle(); o.v = 1; o.pc = 32'h100; o.imm = 32'h20; o.f3 = 3'd0; o.eq = 1;
    o.pt = 1; o.ptgt = 32'h120;
    step(o, 0);
    step(idle(), 0);

    // BLTU mispredict, redirect held 3 cycles, then 2 squashed slots
    o = idle(); o.v = 1; o.pc = 32'h200; o.imm = 32'hFFFF_FFF8; o.f3 = 3'd6; o.ltu = 1;
    step(o, 0);
    for (int i = 0; i < 3; i++) step(idle(), 0);
    o.pt = 1; o.ptgt = 32'h1F8;
    step(o, 1);
    step(o, 0);
    step(o, 0);

    // JALR with bit0 cleared
    o = idle(); o.v = 1; o.pc = 32'h300; o.rs1 = 32'h1003; o.imm = 32'h4; o.jalr = 1;
    o.f3 = 3'd2; o.pt = 1; o.ptgt = 32'h1006;
    step(o, 0);

    // Illegal funct3 predicted taken -> redirect to pc+4
    o = idle(); o.v = 1; o.pc = 32'h400; o.imm = 32'h40; o.f3 = 3'd2; o.pt = 1; o.ptgt = 32'h440;
    step(o, 0);
    step(idle(), 1);
    step(idle(), 0);
    step(idle(), 0);

    // Back-to-back correct predicts up to counter saturation
    for (int i = 0; i < 14; i++) begin
      o = rnd_op(); o.v = 1; o.pt = m_taken(o); o.ptgt = m_target(o);
      step(o, 0);
    end

    // JAL with address wrap, counter already saturated
    o = idle(); o.v = 1; o.pc = 32'hFFFF_FFF0; o.imm = 32'h20; o.jal = 1;
    o.pt = 1; o.ptgt = 32'h0000_0010;
    step(o, 0);
    step(idle(), 0);

    // Async reset in the middle of a redirect
    o = idle(); o.v = 1; o.pc = 32'h500; o.imm = 32'h10; o.f3 = 3'd1; o.eq = 0;
    step(o, 0);
    step(idle(), 0);
    reset_mid();

    for (int i = 0; i < 600; i++) step(rnd_op(), $urandom_range(0, 2) == 0);
    for (int i = 0; i < 4; i++) step(idle(), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
